// File: rtl/fifo_tx_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : fifo_tx_serializer
// Brief    : Pops words from an upstream FIFO and sends each one MSB-first as
//            a start(0) / WIDTH data / stop(1) frame on a single serial wire.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module fifo_tx_serializer #(
  parameter int WIDTH        = 16,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_read,
  output logic             tx,
  output logic             busy,
  output logic             word_done,
  output logic [7:0]       word_count
);

  localparam int CYC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CYC_W-1:0] C_CYC_LAST = CYC_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] C_BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [7:0]       count_q, count_d;

  logic w_cyc_last;
  logic w_can_fetch;

  assign w_cyc_last  = (cyc_q == C_CYC_LAST);
  // Only consulted from IDLE and the final STOP cycle.
  assign w_can_fetch = enable && !fifo_empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        cyc_d = '0;
        bit_d = '0;
        if (w_can_fetch) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // FIFO output is registered, so the popped word is valid only now.
        shift_d = fifo_data;
        cyc_d   = '0;
        bit_d   = '0;
        state_d = S_START;
      end
      S_START: begin
        if (w_cyc_last) begin
          cyc_d   = '0;
          state_d = S_DATA;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_DATA: begin
        if (w_cyc_last) begin
          cyc_d   = '0;
          shift_d = shift_q << 1;
          if (bit_q == C_BIT_LAST) begin
            bit_d   = '0;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_STOP: begin
        if (w_cyc_last) begin
          cyc_d   = '0;
          count_d = count_q + 8'd1;
          state_d = w_can_fetch ? S_FETCH : S_IDLE;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    fifo_read = 1'b0;
    tx        = 1'b1;
    busy      = (state_q != S_IDLE);
    word_done = 1'b0;
    case (state_q)
      S_FETCH: fifo_read = 1'b1;
      S_START: tx        = 1'b0;
      S_DATA:  tx        = shift_q[WIDTH-1];
      S_STOP:  word_done = w_cyc_last;
      default: ;
    endcase
  end

  assign word_count = count_q;

endmodule
`default_nettype wire
